// File: rtl/tmds_pkg.sv
// tmds_pkg: control tokens, lock FSM encoding and default thresholds shared
// by the TMDS receive lane and its word decoder.
package tmds_pkg;

  // Default alignment / lock thresholds.
  localparam int unsigned LOCK_RUN_DEFAULT     = 8;
  localparam int unsigned SEARCH_DWELL_DEFAULT = 2048;
  localparam int unsigned WATCHDOG_DEFAULT     = 4096;

  // The four TMDS control tokens, written as word[9:0].
  localparam logic [9:0] TOKEN_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_CTRL_11 = 10'b1010101011;

  // Highest legal bit-slip offset within the 20-bit capture window.
  localparam logic [3:0] OFFSET_MAX = 4'd9;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } rx_state_e;

  // Next bit-slip position, wrapping from the last offset back to zero.
  function automatic logic [3:0] next_offset(input logic [3:0] k);
    return (k == OFFSET_MAX) ? 4'd0 : k + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_word_decoder.sv
// tmds_word_decoder: purely combinational 10b->8b TMDS decode of one aligned
// word, plus control-token recognition.
module tmds_word_decoder
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_token
);

  logic [7:0] d;

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first); a missed branch would otherwise infer a latch.
  always_comb begin
    d       = word[9] ? ~word[7:0] : word[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Recognise the four control tokens; anything else is a data word.
  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (word)
      TOKEN_CTRL_00: ctrl = 2'b00;
      TOKEN_CTRL_01: ctrl = 2'b01;
      TOKEN_CTRL_10: ctrl = 2'b10;
      TOKEN_CTRL_11: ctrl = 2'b11;
      default:       is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: one TMDS receive lane. Finds the word boundary by slipping
// a 10-bit window across two captured words until a run of control tokens is
// seen, then decodes video/control with registered outputs.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN     = LOCK_RUN_DEFAULT,
  parameter int unsigned SEARCH_DWELL = SEARCH_DWELL_DEFAULT,
  parameter int unsigned WATCHDOG     = WATCHDOG_DEFAULT
) (
  input  logic       clock_pixel,
  input  logic       reset,
  input  logic [9:0] iRaw,
  output logic [7:0] oData,
  output logic [1:0] oCtrl,
  output logic       oDE,
  output logic       oLocked,
  output logic [3:0] oOffset
);

  localparam int RUN_W   = $clog2(LOCK_RUN + 1);
  localparam int DWELL_W = (SEARCH_DWELL > 1) ? $clog2(SEARCH_DWELL) : 1;
  localparam int WD_W    = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;

  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(LOCK_RUN);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(WATCHDOG - 1);

  logic [9:0]         r1_q, r0_q;
  logic [19:0]        window;
  logic [9:0]         aligned;

  rx_state_e          state_q, state_d;
  logic [3:0]         offset_q, offset_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               de_q, de_d;

  logic [7:0]         dec_data;
  logic [1:0]         dec_ctrl;
  logic               dec_is_token;

  // Capture two consecutive raw words; the older one holds the earlier bits.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value, independent of statement order.
  always_ff @(posedge clock_pixel) begin
    if (reset) begin
      r1_q <= '0;
      r0_q <= '0;
    end else begin
      r1_q <= iRaw;
      r0_q <= r1_q;
    end
  end

  assign window  = {r1_q, r0_q};
  assign aligned = window[{1'b0, offset_q} +: 10];

  tmds_word_decoder u_decoder (
    .word     (aligned),
    .data     (dec_data),
    .ctrl     (dec_ctrl),
    .is_token (dec_is_token)
  );

  // Next-state: token run, search dwell / bit slip, locked watchdog, outputs.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    wd_d     = wd_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    de_d     = 1'b0;

    // Consecutive tokens at the current offset, saturating at the lock run.
    if (!dec_is_token)         run_d = '0;
    else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
    else                       run_d = run_q;

    case (state_q)
      ST_SEARCH: begin
        // A completed run beats a dwell expiry in the same cycle.
        if (run_q == RUN_MAX) begin
          state_d = ST_LOCKED;
          dwell_d = '0;
          wd_d    = '0;
        end else if (dwell_q == DWELL_LAST) begin
          offset_d = next_offset(offset_q);
          run_d    = '0;
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (run_q == RUN_MAX) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d  = ST_SEARCH;
          offset_d = next_offset(offset_q);
          run_d    = '0;
          dwell_d  = '0;
          wd_d     = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    // Outputs follow the state being entered so they agree with oLocked.
    if (state_d == ST_LOCKED) begin
      if (dec_is_token) begin
        ctrl_d = dec_ctrl;
      end else begin
        data_d = dec_data;
        de_d   = 1'b1;
      end
    end else begin
      data_d = '0;
      ctrl_d = '0;
    end
  end

  // Lock FSM, counters and registered decode outputs.
  always_ff @(posedge clock_pixel) begin
    if (reset) begin
      state_q  <= ST_SEARCH;
      offset_q <= '0;
      run_q    <= '0;
      dwell_q  <= '0;
      wd_q     <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      dwell_q  <= dwell_d;
      wd_q     <= wd_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
    end
  end

  assign oData   = data_q;
  assign oCtrl   = ctrl_q;
  assign oDE     = de_q;
  assign oLocked = (state_q == ST_LOCKED);
  assign oOffset = offset_q;

endmodule
